// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared W-bit parallel-prefix adder
// walks the operands least significant word first, chaining the carry through a register.

module sum_prefix #(
  parameter int LOGWIDTH = 5
) (
  input  logic [(2**LOGWIDTH)-1:0] A,
  input  logic [(2**LOGWIDTH)-1:0] B,
  input  logic                     Cin,
  output logic [(2**LOGWIDTH)-1:0] S,
  output logic                     Cout
);
  localparam int W = 2**LOGWIDTH;

  // Kogge-Stone tree: level l holds group generate/propagate spanning 2**l bits ending at bit i.
  logic [W-1:0] g [0:LOGWIDTH];
  logic [W-1:0] p [0:LOGWIDTH];
  logic [W:0]   c;

  assign g[0] = A & B;
  assign p[0] = A ^ B;

  for (genvar l = 1; l <= LOGWIDTH; l++) begin : g_level
    localparam int D = 2**(l-1);
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i-D]);
        assign p[l][i] = p[l-1][i] & p[l-1][i-D];
      end else begin : g_pass
        assign g[l][i] = g[l-1][i];
        assign p[l][i] = p[l-1][i];
      end
    end
  end

  // Final prefixes span bit 0 upward, so the carry-in folds in with one AND-OR per bit.
  assign c[0] = Cin;
  for (genvar i = 0; i < W; i++) begin : g_carry
    assign c[i+1] = g[LOGWIDTH][i] | (p[LOGWIDTH][i] & Cin);
  end

  assign S    = p[0] ^ c[W-1:0];
  assign Cout = c[W];
endmodule

module mp_add_seq #(
  parameter int LOGWIDTH = 5,
  parameter int WORDS    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_valid,
  output logic                                  start_ready,
  input  logic                                  sub,
  input  logic [WORDS*(2**LOGWIDTH)-1:0]        A,
  input  logic [WORDS*(2**LOGWIDTH)-1:0]        B,
  output logic                                  done_valid,
  input  logic                                  done_ready,
  output logic [WORDS*(2**LOGWIDTH)-1:0]        S,
  output logic                                  Cout,
  output logic                                  Ovf
);
  localparam int W    = 2**LOGWIDTH;
  localparam int N    = WORDS * W;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            sub_reg;
  logic            carry_reg;
  logic [IDXW-1:0] idx;

  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_cin;
  logic [W-1:0]    add_s;
  logic            add_co;

  // NOTE: operand registers are pure datapath, only meaningful after an accept,
  // so they carry no reset and cost no reset routing.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_valid) begin
      a_reg   <= A;
      b_reg   <= B;
      sub_reg <= sub;
    end
  end

  // Adder inputs are held at zero outside RUN so the tree does not toggle while idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx*W +: W];
      add_b   = b_reg[idx*W +: W] ^ {W{sub_reg}};
      add_cin = carry_reg;
    end
  end

  sum_prefix #(.LOGWIDTH(LOGWIDTH)) u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin),
    .S    (add_s),
    .Cout (add_co)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      done_valid  <= 1'b0;
      S           <= '0;
      Cout        <= 1'b0;
      Ovf         <= 1'b0;
      idx         <= '0;
      carry_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            carry_reg   <= sub;
            idx         <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          S[idx*W +: W] <= add_s;
          carry_reg     <= add_co;
          if (idx == LAST) begin
            Cout       <= add_co;
            Ovf        <= (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
            done_valid <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // start_valid is deliberately ignored here; a new command waits for IDLE.
          if (done_ready) begin
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          done_valid  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq at default parameters (4 x 32-bit words):
// carries, borrows, signed overflow, result backpressure and mid-operation reset.

module tb_mp_add_seq;
  localparam int N = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic         sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         done_valid;
  logic         done_ready;
  logic [N-1:0] S;
  logic         Cout;
  logic         Ovf;

  int vectors    = 0;
  int miscompares = 0;

  mp_add_seq #(.LOGWIDTH(5), .WORDS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sub         (sub),
    .A           (A),
    .B           (B),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .S           (S),
    .Cout        (Cout),
    .Ovf         (Ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command, scramble the inputs after the accept edge, and check
  // the WORDS-cycle latency and the result. Optionally accept the result.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic [N-1:0] es, input logic ec,
                        input logic ev, input bit release_result);
    check({tag, " ready before"}, 128'(start_ready), 128'(1'b1));
    start_valid = 1'b1;
    A = a;
    B = b;
    sub = s;
    tick();
    start_valid = 1'b0;
    A = ~a;
    B = ~b;
    sub = ~s;
    check({tag, " ready busy"}, 128'(start_ready), 128'(1'b0));
    for (int k = 0; k < 4; k++) begin
      check({tag, " not yet done"}, 128'(done_valid), 128'(1'b0));
      tick();
    end
    check({tag, " done_valid"}, 128'(done_valid), 128'(1'b1));
    check({tag, " S"}, S, es);
    check({tag, " Cout"}, 128'(Cout), 128'(ec));
    check({tag, " Ovf"}, 128'(Ovf), 128'(ev));
    if (release_result) begin
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      check({tag, " released"}, 128'(done_valid), 128'(1'b0));
      check({tag, " S kept in idle"}, S, es);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    sub         = 1'b0;
    A           = '0;
    B           = '0;
    tick();
    tick();
    reset = 1'b0;

    check("reset start_ready", 128'(start_ready), 128'(1'b1));
    check("reset done_valid", 128'(done_valid), 128'(1'b0));
    check("reset S", S, '0);
    check("reset Cout", 128'(Cout), 128'(1'b0));
    check("reset Ovf", 128'(Ovf), 128'(1'b0));

    run_op("allones+1", {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0, 1'b1);
    run_op("word carry", 128'h0000_0000_FFFF_FFFF, 128'd1, 1'b0,
           128'h1_0000_0000, 1'b0, 1'b0, 1'b1);
    run_op("5-7", 128'd5, 128'd7, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
    run_op("7-5", 128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0, 1'b1);
    run_op("max+1", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
           128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    run_op("min-1", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b1,
           128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);

    // Carries ripple through words 0..2 into word 3; result then held under backpressure.
    run_op("multi carry", 128'h0000_0001_FFFF_FFFF_0000_0000_8000_0000,
           128'h0000_0000_0000_0001_FFFF_FFFF_8000_0000, 1'b0,
           128'h0000_0002_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    start_valid = 1'b1;
    sub = 1'b0;
    for (int k = 0; k < 5; k++) begin
      A = 128'd100 + 128'(k);
      B = 128'd23;
      tick();
      check("hold S", S, 128'h0000_0002_0000_0001_0000_0000_0000_0000);
      check("hold Cout", 128'(Cout), 128'(1'b0));
      check("hold Ovf", 128'(Ovf), 128'(1'b0));
      check("hold start_ready", 128'(start_ready), 128'(1'b0));
      check("hold done_valid", 128'(done_valid), 128'(1'b1));
    end
    A = 128'd100;
    B = 128'd23;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("accept in done: idle", 128'(start_ready), 128'(1'b1));
    check("accept in done: no valid", 128'(done_valid), 128'(1'b0));
    tick();
    start_valid = 1'b0;
    A = '1;
    B = '1;
    check("start taken in idle", 128'(start_ready), 128'(1'b0));
    for (int k = 0; k < 4; k++) tick();
    check("post-hold done", 128'(done_valid), 128'(1'b1));
    check("post-hold S", S, 128'd123);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // Reset while idx==2 discards the operation and clears the result.
    start_valid = 1'b1;
    A = {128{1'b1}};
    B = 128'd1;
    sub = 1'b0;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun reset start_ready", 128'(start_ready), 128'(1'b1));
    check("midrun reset done_valid", 128'(done_valid), 128'(1'b0));
    check("midrun reset S", S, '0);
    check("midrun reset Cout", 128'(Cout), 128'(1'b0));
    check("midrun reset Ovf", 128'(Ovf), 128'(1'b0));
    tick();
    check("midrun reset stays idle", 128'(done_valid), 128'(1'b0));

    run_op("3+4", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
